// File: rtl/scan_fsm_pkg.sv
// Shared types and constant functions for the scan-inserted sequence detector.
package scan_fsm_pkg;

    typedef enum logic {
        SCAN_MODE_FUNC  = 1'b0,
        SCAN_MODE_SHIFT = 1'b1
    } scan_mode_e;

    function automatic int calc_sw(input int pat_len);
        int w;
        w = $clog2(pat_len);
        return (w < 1) ? 1 : w;
    endfunction

    // Next state after matching s prefix bits and then receiving b: the longest
    // proper prefix of the pattern that is a suffix of (prefix[0..s-1], b).
    // Received-order bit i of the pattern is pattern[pat_len-1-i].
    function automatic int kmp_next(input int pat_len, input logic [31:0] pattern,
                                    input int s, input logic b);
        logic [32:0] str;
        int          len;
        int          kmax;
        int          res;
        logic        ok;
        str = '0;
        for (int i = 0; i < s; i++) begin
            str[i] = pattern[pat_len-1-i];
        end
        str[s] = b;
        len  = s + 1;
        kmax = (len < pat_len) ? len : pat_len - 1;
        res  = 0;
        for (int k = 1; k <= kmax; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (str[len-k+j] != pattern[pat_len-1-j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_dff.sv
// Mux-D scan flop: synchronous reset wins, then scan select, then functional data.
module scan_dff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic si,
    input  logic se,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else if (se) begin
            r_q <= si;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/scan_seq_fsm.sv
// Scan-inserted programmable sequence detector with saturating match counter.
// Optional build macro SCAN_FSM_BYPASS_EN adds a one-flop scan bypass path.
//
// state           | meaning
// 0..PAT_LEN-1    | number of pattern prefix bits currently matched
// >= PAT_LEN      | illegal (scan load only), next state computed as from 0
module scan_seq_fsm
    import scan_fsm_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b111,
    parameter int                 CNT_W   = 4,
    localparam int                SW      = calc_sw(PAT_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             scan_en,
    input  logic             scan_in,
`ifdef SCAN_FSM_BYPASS_EN
    input  logic             scan_bypass,
`endif
    output logic             scan_out,
    output logic [SW-1:0]    state_out,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int          L     = SW + CNT_W + 1;
    localparam int          TBL_N = 2 ** (SW + 1);
    localparam logic [31:0] PAT32 = 32'(PATTERN);

    logic [SW-1:0]    w_nxt_tbl [TBL_N];
    logic             w_hit_tbl [TBL_N];

    logic [L-1:0]     w_q;
    logic [L-1:0]     w_si;
    logic [L-1:0]     w_d;
    logic [L-1:0]     w_func_d;
    logic [SW-1:0]    w_state;
    logic [SW-1:0]    w_state_eff;
    logic [SW:0]      w_idx;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_hit;
    logic             w_se;
    scan_mode_e       w_mode;

    // Transition table indexed by {state, in}; entries past 2*PAT_LEN are unreachable.
    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
        if (gi < 2 * PAT_LEN) begin : g_used
            assign w_nxt_tbl[gi] = SW'(kmp_next(PAT_LEN, PAT32, gi / 2, 1'(gi % 2)));
            assign w_hit_tbl[gi] = ((gi / 2) == (PAT_LEN - 1)) && (PAT32[0] == 1'(gi % 2));
        end else begin : g_unused
            assign w_nxt_tbl[gi] = '0;
            assign w_hit_tbl[gi] = 1'b0;
        end
    end

    // Chain vector, MSB first in shift order: state, count, match.
    assign w_state     = w_q[L-1 -: SW];
    assign w_cnt       = w_q[CNT_W:1];
    assign w_state_eff = ({1'b0, w_state} >= (SW + 1)'(PAT_LEN)) ? '0 : w_state;
    assign w_idx       = {w_state_eff, in};
    assign w_hit       = w_hit_tbl[w_idx];
    assign w_cnt_nxt   = (w_hit && (w_cnt != '1)) ? w_cnt + CNT_W'(1) : w_cnt;
    assign w_func_d    = {w_nxt_tbl[w_idx], w_cnt_nxt, w_hit};
    assign w_si        = {scan_in, w_q[L-1:1]};
    assign w_mode      = scan_mode_e'(scan_en);

`ifdef SCAN_FSM_BYPASS_EN
    logic w_byp_act;
    logic w_byp_q;

    assign w_byp_act = (w_mode == SCAN_MODE_SHIFT) && scan_bypass;

    scan_dff u_byp (
        .clk   (clk),
        .reset (reset),
        .d     (w_byp_q),
        .si    (scan_in),
        .se    (w_byp_act),
        .q     (w_byp_q)
    );

    // While bypassing, the main chain holds by recirculating its own Q.
    assign w_se     = (w_mode == SCAN_MODE_SHIFT) && !w_byp_act;
    assign w_d      = w_byp_act ? w_q : w_func_d;
    assign scan_out = w_byp_act ? w_byp_q : w_q[0];
`else
    assign w_se     = (w_mode == SCAN_MODE_SHIFT);
    assign w_d      = w_func_d;
    assign scan_out = w_q[0];
`endif

    for (genvar gb = 0; gb < L; gb++) begin : g_chain
        scan_dff u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (w_d[gb]),
            .si    (w_si[gb]),
            .se    (w_se),
            .q     (w_q[gb])
        );
    end

    assign state_out   = w_state;
    assign match_count = w_cnt;
    assign match       = w_q[0];

endmodule

// File: tb/tb_scan_seq_fsm.sv
// Self-checking bench: two detector instances (patterns 111 and 101) against a
// history/suffix-matching reference model and a list-based scan chain model.
module tb_scan_seq_fsm;

    localparam int PLEN = 3;
    localparam int SWB  = 2;
    localparam int CW   = 4;
    localparam int LCH  = SWB + CW + 1;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic scan_en;
    logic scan_in;
`ifdef SCAN_FSM_BYPASS_EN
    logic scan_bypass;
`endif

    logic           so_a, m_a, so_b, m_b;
    logic [SWB-1:0] st_a, st_b;
    logic [CW-1:0]  cnt_a, cnt_b;

    int n_chk = 0;
    int n_err = 0;

    int pat     [2] = '{7, 5};
    int m_state [2];
    int m_cnt   [2];
    bit m_match [2];
    bit m_byp;

    always #5 clk = ~clk;

    scan_seq_fsm dut_a (
        .clk         (clk),
        .reset       (reset),
        .in          (din),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
`ifdef SCAN_FSM_BYPASS_EN
        .scan_bypass (scan_bypass),
`endif
        .scan_out    (so_a),
        .state_out   (st_a),
        .match       (m_a),
        .match_count (cnt_a)
    );

    scan_seq_fsm #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(4)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .in          (din),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
`ifdef SCAN_FSM_BYPASS_EN
        .scan_bypass (scan_bypass),
`endif
        .scan_out    (so_b),
        .state_out   (st_b),
        .match       (m_b),
        .match_count (cnt_b)
    );

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit byp_active();
`ifdef SCAN_FSM_BYPASS_EN
        return (scan_en === 1'b1) && (scan_bypass === 1'b1);
`else
        return 1'b0;
`endif
    endfunction

    // i-th received bit of the pattern (i = 0 arrives first)
    function automatic bit pat_bit(input int p, input int i);
        return bit'((p >> (PLEN - 1 - i)) & 1);
    endfunction

    function automatic bit ends_with(input bit h[$], input int p, input int k);
        if (k > h.size()) return 1'b0;
        for (int j = 0; j < k; j++) begin
            if (h[h.size() - k + j] != pat_bit(p, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_func(input int k, input bit b);
        bit h[$];
        int best;
        if (m_state[k] < PLEN) begin
            for (int i = 0; i < m_state[k]; i++) h.push_back(pat_bit(pat[k], i));
        end
        h.push_back(b);
        m_match[k] = (h.size() == PLEN) && ends_with(h, pat[k], PLEN);
        best = 0;
        for (int kk = 1; kk < PLEN; kk++) begin
            if (ends_with(h, pat[k], kk)) best = kk;
        end
        m_state[k] = best;
        if (m_match[k] && m_cnt[k] < CMAX) m_cnt[k]++;
    endtask

    task automatic model_shift(input int k, input bit si);
        bit c[LCH];
        for (int i = 0; i < SWB; i++) c[i] = bit'((m_state[k] >> (SWB - 1 - i)) & 1);
        for (int i = 0; i < CW; i++)  c[SWB + i] = bit'((m_cnt[k] >> (CW - 1 - i)) & 1);
        c[LCH - 1] = m_match[k];
        for (int i = LCH - 1; i > 0; i--) c[i] = c[i - 1];
        c[0] = si;
        m_state[k] = 0;
        m_cnt[k]   = 0;
        for (int i = 0; i < SWB; i++) m_state[k] = (m_state[k] << 1) | int'(c[i]);
        for (int i = 0; i < CW; i++)  m_cnt[k]   = (m_cnt[k] << 1) | int'(c[SWB + i]);
        m_match[k] = c[LCH - 1];
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0;
                m_cnt[k]   = 0;
                m_match[k] = 1'b0;
            end
            m_byp = 1'b0;
        end else if (scan_en && byp_active()) begin
            m_byp = scan_in;
        end else if (scan_en) begin
            for (int k = 0; k < 2; k++) model_shift(k, scan_in);
        end else begin
            for (int k = 0; k < 2; k++) model_func(k, din);
        end
    endtask

    task automatic check_all(input string tag);
        chk_eq({tag, ":a_state"}, int'(st_a), m_state[0]);
        chk_eq({tag, ":a_match"}, int'(m_a), int'(m_match[0]));
        chk_eq({tag, ":a_count"}, int'(cnt_a), m_cnt[0]);
        chk_eq({tag, ":a_so"}, int'(so_a), byp_active() ? int'(m_byp) : int'(m_match[0]));
        chk_eq({tag, ":b_state"}, int'(st_b), m_state[1]);
        chk_eq({tag, ":b_match"}, int'(m_b), int'(m_match[1]));
        chk_eq({tag, ":b_count"}, int'(cnt_b), m_cnt[1]);
        chk_eq({tag, ":b_so"}, int'(so_b), byp_active() ? int'(m_byp) : int'(m_match[1]));
    endtask

    task automatic cyc(input string tag, input bit r, input bit se, input bit si, input bit d);
        reset   = r;
        scan_en = se;
        scan_in = si;
        din     = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int exp_st [5] = '{0, 1, 2, 2, 2};
        int exp_ma [5] = '{0, 0, 0, 1, 1};
        int exp_mb [5] = '{0, 0, 1, 0, 1};
        bit seq1   [5] = '{0, 1, 1, 1, 1};
        bit seq2   [5] = '{1, 0, 1, 0, 1};
        bit ld_ok  [7] = '{1, 1, 0, 0, 0, 0, 1};
        bit ld_bad [7] = '{0, 0, 0, 0, 0, 1, 1};

        reset   = 1'b1;
        din     = 1'b0;
        scan_en = 1'b0;
        scan_in = 1'b0;
`ifdef SCAN_FSM_BYPASS_EN
        scan_bypass = 1'b0;
`endif
        m_byp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_cnt[k]   = 0;
            m_match[k] = 1'b0;
        end

        cyc("rst", 1, 0, 0, 0);
        chk_eq("rst_a_state", int'(st_a), 0);
        chk_eq("rst_a_so", int'(so_a), 0);

        for (int i = 0; i < 5; i++) begin
            cyc("seq111", 0, 0, 0, seq1[i]);
            chk_eq("seq111_state", int'(st_a), exp_st[i]);
            chk_eq("seq111_match", int'(m_a), exp_ma[i]);
        end
        chk_eq("seq111_count", int'(cnt_a), 2);

        cyc("rst2", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("seq101", 0, 0, 0, seq2[i]);
            chk_eq("seq101_match", int'(m_b), exp_mb[i]);
        end
        chk_eq("seq101_count", int'(cnt_b), 2);
        chk_eq("seq101_state", int'(st_b), 1);

        cyc("rst3", 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("load", 0, 1, ld_ok[i], 0);
        chk_eq("load_state", int'(st_a), 2);
        chk_eq("load_count", int'(cnt_a), 1);
        chk_eq("load_match", int'(m_a), 1);
        chk_eq("load_so", int'(so_a), 1);
        cyc("post_load", 0, 0, 0, 1);
        chk_eq("post_load_a_match", int'(m_a), 1);
        chk_eq("post_load_a_count", int'(cnt_a), 2);
        chk_eq("post_load_b_match", int'(m_b), 1);
        chk_eq("post_load_b_count", int'(cnt_b), 2);

        for (int i = 0; i < 7; i++) cyc("ld_ill", 0, 1, ld_bad[i], 0);
        chk_eq("ill_state", int'(st_a), 3);
        cyc("ill_fn", 0, 0, 0, 1);
        chk_eq("ill_a_state", int'(st_a), 1);
        chk_eq("ill_a_match", int'(m_a), 0);
        chk_eq("ill_b_state", int'(st_b), 1);

        cyc("rst4", 1, 0, 0, 0);
        for (int i = 0; i < 22; i++) cyc("sat", 0, 0, 0, 1);
        chk_eq("sat_count", int'(cnt_a), 15);
        chk_eq("sat_match", int'(m_a), 1);

        cyc("mid_sh", 0, 1, 1, 0);
        cyc("mid_sh", 0, 1, 1, 0);
        cyc("mid_rst", 1, 1, 1, 0);
        chk_eq("mid_rst_state", int'(st_a), 0);
        chk_eq("mid_rst_count", int'(cnt_a), 0);
        chk_eq("mid_rst_match", int'(m_a), 0);
        chk_eq("mid_rst_so", int'(so_a), 0);

        for (int i = 0; i < 400; i++) begin
            bit r;
            bit se;
            r  = ($urandom_range(0, 49) == 0);
            se = ($urandom_range(0, 5) == 0) ? !scan_en : scan_en;
`ifdef SCAN_FSM_BYPASS_EN
            scan_bypass = ($urandom_range(0, 3) == 0);
`endif
            cyc("rand", r, se, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

`ifdef SCAN_FSM_BYPASS_EN
        scan_bypass = 1'b0;
        cyc("byp_rst", 1, 0, 0, 0);
        cyc("byp_pre", 0, 0, 0, 1);
        scan_bypass = 1'b1;
        cyc("byp", 0, 1, 1, 0);
        chk_eq("byp_so0", int'(so_a), 1);
        cyc("byp", 0, 1, 0, 0);
        chk_eq("byp_so1", int'(so_a), 0);
        cyc("byp", 0, 1, 1, 0);
        chk_eq("byp_so2", int'(so_a), 1);
        chk_eq("byp_state", int'(st_a), 1);
        chk_eq("byp_count", int'(cnt_a), 0);
        scan_bypass = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
